dsel_arbiter: RTL and testbench
===============================

// Module: dsel_arbiter
// PURPOSE
//  Two-channel packet arbiter/sequencer feeding the dsel datapath. Shares one output stream between
//  ch0/ch1 under the dsel register settings (channel_sel, data_inv) plus an arb_mode bit.
//  Grants whole packets, applies optional bit inversion, registers the output (1 stage).
//  Sits between the upstream sources and the dsel output interface; configured from dsel_regfile.
// PARAMETERS
//  DWIDTH     32  data width of channels and output
//  MAX_BURST  16  max beats per packet; packet force-terminated at this beat (>=2)
//  CNT_WIDTH  16  width of packet counters (DSEL_ARB_STAT_EN only)
// PORTS
//  pclk        in   1          clock
//  rst         in   1          reset; asynchronous, active-high
//  arb_mode    in   1          0 = fixed (channel_sel picks source), 1 = round-robin
//  channel_sel in   1          fixed-mode source select
//  data_inv    in   1          1 = output data is bitwise inverted
//  chN_valid   in   1          N=0,1: source beat valid
//  chN_data    in   DWIDTH     N=0,1: source beat data
//  chN_last    in   1          N=0,1: last beat of packet
//  chN_ready   out  1          N=0,1: beat accepted when chN_valid & chN_ready
//  out_valid   out  1          registered output beat valid
//  out_data    out  DWIDTH     registered output data
//  out_last    out  1          registered last-beat flag
//  out_ready   in   1          downstream accept
//  grant_id    out  1          channel currently/last granted
//  busy        out  1          1 while a packet is in progress (state != IDLE)
//  trunc_err   out  1          sticky: a packet was force-terminated at MAX_BURST
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_last=0, grant_id=0, busy=0, trunc_err=0, chN_ready=0,
//    state=IDLE, last_grant=1 (ch0 wins first RR tie), beat_cnt=0, config latches=0.
//  - FSM IDLE/GNT0/GNT1. IDLE->GNTx on the cycle a request is seen; first beat accepted the next cycle.
//  - Fixed mode: only chX where X=channel_sel requests; other channel is never readied.
//  - RR mode: one valid -> grant it; both valid -> grant !last_grant. last_grant updated on grant.
//  - arb_mode/channel_sel/data_inv latched on IDLE->GNTx; changes mid-packet have no effect.
//  - Accept: chX_ready = (state==GNTx) & (~out_valid | out_ready), combinational; 0 in IDLE.
//  - On accept: out_data <= chX_data ^ {DWIDTH{inv_l}}, out_valid<=1, out_last per below.
//    Latency chX accept -> out_valid = 1 cycle; full throughput (1 beat/cycle) within a packet.
//  - out_valid cleared when out_ready & no new accept that cycle; out_data held while stalled.
//  - beat_cnt counts accepted beats of current packet. Packet ends on accept with chX_last=1 or
//    beat_cnt==MAX_BURST-1 (MAX_BURSTth beat): out_last<=1, GNTx->IDLE, beat_cnt<=0.
//    If forced (last=0 on MAX_BURSTth beat): trunc_err<=1 (sticky until rst); remaining source
//    beats arbitrate as a new packet.
//  - 1 idle bubble between packets (IDLE cycle). Single-beat packet (last on beat 1) legal.
//  - grant_id updated on IDLE->GNTx, held in IDLE. busy = state!=IDLE.
//  - rst mid-packet: all state/outputs to reset values immediately; in-flight beat dropped.
// CONFIGURATION
//  - DSEL_ARB_STAT_EN defined: adds ports cnt_clr(in,1), pkt_cnt0/pkt_cnt1(out,CNT_WIDTH).
//    pkt_cntN +1 on each completed (out_last accepted at chN input) packet of chN; wraps to 0;
//    cnt_clr zeroes both (clear wins over simultaneous increment). Reset 0.
//  - Not defined: those ports and counters absent; all other behaviour identical.
// TESTING
//  - Reset: assert rst mid-packet -> all outputs 0, busy=0 next edge; first RR grant after = ch0.
//  - Fixed, channel_sel=1, both valid, 3-beat pkts -> only ch1 beats out; ch0_ready stays 0.
//  - RR, both always valid, 2-beat pkts -> grant order 0,1,0,1; 1 bubble cycle between packets.
//  - data_inv=1, data 0x0000_00FF -> out_data 0xFFFF_FF00; toggle data_inv mid-packet -> no change.
//  - 20-beat pkt w/o last, MAX_BURST=16 -> out_last on beat 16, trunc_err=1, beats 17-20 new pkt.
//  - out_ready low 3 cycles mid-packet -> out_data held, chX_ready=0, no beat lost or duplicated.

Source files
------------

// File: rtl/dsel_arbiter.sv
// dsel_arbiter: two-channel whole-packet arbiter with optional inversion and a registered output.
// Define DSEL_ARB_STAT_EN to add per-channel completed-packet counters (cnt_clr, pkt_cnt0/1).

module dsel_arbiter #(
    parameter int DWIDTH    = 32,
    parameter int MAX_BURST = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              arb_mode,
    input  logic              channel_sel,
    input  logic              data_inv,
    input  logic              ch0_valid,
    input  logic [DWIDTH-1:0] ch0_data,
    input  logic              ch0_last,
    output logic              ch0_ready,
    input  logic              ch1_valid,
    input  logic [DWIDTH-1:0] ch1_data,
    input  logic              ch1_last,
    output logic              ch1_ready,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              grant_id,
    output logic              busy,
`ifdef DSEL_ARB_STAT_EN
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] pkt_cnt0,
    output logic [CNT_WIDTH-1:0] pkt_cnt1,
`endif
    output logic              trunc_err
);

    localparam int BW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;

    if (MAX_BURST < 2 || CNT_WIDTH < 1) begin : g_bad_param
        $error("dsel_arbiter: MAX_BURST must be >= 2 and CNT_WIDTH >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT0 = 2'd1,
        S_GNT1 = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [DWIDTH-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              inv_q, inv_d;
    logic              trunc_q, trunc_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;

    logic              req0, req1, pick1, start;
    logic              can_take, sel_ch1, acc;
    logic [DWIDTH-1:0] acc_data;
    logic              acc_last, at_max, pkt_end, forced;

    // Live config decides the request; it is latched only when a grant starts.
    always_comb begin
        req0 = 1'b0;
        req1 = 1'b0;
        if (arb_mode) begin
            req0 = ch0_valid;
            req1 = ch1_valid;
        end else begin
            req0 = ch0_valid & ~channel_sel;
            req1 = ch1_valid & channel_sel;
        end
    end

    assign pick1 = req1 & (~req0 | ~last_grant_q);
    assign start = (state_q == S_IDLE) & (req0 | req1);

    assign can_take = ~out_valid_q | out_ready;
    assign sel_ch1  = (state_q == S_GNT1);
    assign acc      = (ch0_valid & ch0_ready) | (ch1_valid & ch1_ready);
    assign acc_data = sel_ch1 ? ch1_data : ch0_data;
    assign acc_last = sel_ch1 ? ch1_last : ch0_last;
    assign at_max   = (beat_cnt_q == BW'(MAX_BURST - 1));
    assign pkt_end  = acc & (acc_last | at_max);
    assign forced   = acc & at_max & ~acc_last;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = pick1 ? S_GNT1 : S_GNT0;
                end
            end
            S_GNT0, S_GNT1: begin
                if (pkt_end) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ch0_ready = 1'b0;
        ch1_ready = 1'b0;
        unique case (state_q)
            S_GNT0:  ch0_ready = can_take;
            S_GNT1:  ch1_ready = can_take;
            default: ;
        endcase
    end

    assign busy = (state_q != S_IDLE);

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        beat_cnt_d   = beat_cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        inv_d        = inv_q;
        trunc_d      = trunc_q | forced;

        if (acc) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_data ^ {DWIDTH{inv_q}};
            out_last_d  = pkt_end;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (pkt_end) begin
            beat_cnt_d = '0;
        end else if (acc) begin
            beat_cnt_d = beat_cnt_q + BW'(1);
        end

        if (start) begin
            grant_d      = pick1;
            last_grant_d = pick1;
            inv_d        = data_inv;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            beat_cnt_q   <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            inv_q        <= 1'b0;
            trunc_q      <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            beat_cnt_q   <= beat_cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            inv_q        <= inv_d;
            trunc_q      <= trunc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign grant_id  = grant_q;
    assign trunc_err = trunc_q;

`ifdef DSEL_ARB_STAT_EN
    logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;

    // Clear takes priority over a packet completing in the same cycle.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (cnt_clr) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else if (pkt_end) begin
            if (sel_ch1) begin
                cnt1_d = cnt1_q + CNT_WIDTH'(1);
            end else begin
                cnt0_d = cnt0_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;
`endif

`ifndef SYNTHESIS
    a_excl_ready : assert property (
        @(posedge pclk) disable iff (rst) !(ch0_ready && ch1_ready));
    a_hold_stall : assert property (
        @(posedge pclk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));
`endif

endmodule

// File: tb/tb_dsel_arbiter.sv
// tb_dsel_arbiter: vector table plus hand-written sequences for dsel_arbiter.
// Source queues feed the DUT; a scoreboard holds expected output beats.

module tb_dsel_arbiter;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        arb_mode = 1'b0;
    logic        channel_sel = 1'b0;
    logic        data_inv = 1'b0;
    logic        ch0_valid = 1'b0;
    logic [31:0] ch0_data = '0;
    logic        ch0_last = 1'b0;
    logic        ch0_ready;
    logic        ch1_valid = 1'b0;
    logic [31:0] ch1_data = '0;
    logic        ch1_last = 1'b0;
    logic        ch1_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic        grant_id;
    logic        busy;
    logic        trunc_err;
`ifdef DSEL_ARB_STAT_EN
    logic        cnt_clr = 1'b0;
    logic [15:0] pkt_cnt0;
    logic [15:0] pkt_cnt1;
`endif

    always #5 pclk = ~pclk;

    dsel_arbiter #(.DWIDTH(32), .MAX_BURST(16), .CNT_WIDTH(16)) dut (
        .pclk(pclk), .rst(rst),
        .arb_mode(arb_mode), .channel_sel(channel_sel), .data_inv(data_inv),
        .ch0_valid(ch0_valid), .ch0_data(ch0_data),
        .ch0_last(ch0_last), .ch0_ready(ch0_ready),
        .ch1_valid(ch1_valid), .ch1_data(ch1_data),
        .ch1_last(ch1_last), .ch1_ready(ch1_ready),
        .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready),
        .grant_id(grant_id), .busy(busy),
`ifdef DSEL_ARB_STAT_EN
        .cnt_clr(cnt_clr), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
`endif
        .trunc_err(trunc_err)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic        arb;
        logic        sel;
        logic        inv;
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
        int          exp_grant;
        logic [31:0] exp_data;
    } vec_t;

    beat_t src0[$];
    beat_t src1[$];
    beat_t sb[$];

    int          n_chk = 0;
    int          n_pass = 0;
    int          beat_n = 0;
    logic        pkt_inv = 1'b0;
    int          acc_cnt = 0;
    int          acc_ch = -1;
    int          cyc_acc = -1;
    int          n0_acc = 0;
    int          n1_acc = 0;
    int          pops = 0;
    int          last_pops = 0;
    logic [31:0] last_out = '0;
    logic        mon_no_ch0 = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail(input string name, input string msg);
        n_chk++;
        $display("FAIL %s: %s", name, msg);
    endtask

    task automatic drive();
        ch0_valid = (src0.size() > 0);
        ch0_data  = (src0.size() > 0) ? src0[0].data : 32'h0;
        ch0_last  = (src0.size() > 0) ? src0[0].last : 1'b0;
        ch1_valid = (src1.size() > 0);
        ch1_data  = (src1.size() > 0) ? src1[0].data : 32'h0;
        ch1_last  = (src1.size() > 0) ? src1[0].last : 1'b0;
    endtask

    // Reference model of one accepted beat: inversion fixed per packet, forced end at beat 16.
    task automatic accept_beat(input int ch);
        beat_t b;
        beat_t e;
        check("acc_grant_id", 32'(grant_id), 32'(ch));
        b = (ch == 1) ? src1.pop_front() : src0.pop_front();
        if (beat_n == 0) pkt_inv = data_inv;
        beat_n++;
        e.data = b.data ^ {32{pkt_inv}};
        e.last = b.last || (beat_n == 16);
        if (e.last) beat_n = 0;
        sb.push_back(e);
        cyc_acc = ch;
        acc_ch = ch;
        acc_cnt++;
        if (ch == 1) n1_acc++;
        else n0_acc++;
    endtask

    task automatic step();
        beat_t b;
        logic  a0, a1;
        #1;
        a0 = ch0_valid & ch0_ready;
        a1 = ch1_valid & ch1_ready;
        cyc_acc = -1;
        if (mon_no_ch0) check("fix_ch0_ready", 32'(ch0_ready), 32'h0);
        if (a0 && a1) fail("excl_accept", "both channels accepted in one cycle");
        if (a0) accept_beat(0);
        if (a1) accept_beat(1);
        if (out_valid && out_ready) begin
            pops++;
            last_out = out_data;
            if (out_last) last_pops++;
            if (sb.size() == 0) begin
                $display("FAIL sb_underflow: got beat %h expected none", out_data);
                n_chk++;
            end else begin
                b = sb.pop_front();
                check("out_data", out_data, b.data);
                check("out_last", 32'(out_last), 32'(b.last));
            end
        end
        @(posedge pclk);
        @(negedge pclk);
        drive();
    endtask

    task automatic clear_all();
        src0.delete();
        src1.delete();
        sb.delete();
        beat_n = 0;
        drive();
    endtask

    task automatic do_reset();
        @(negedge pclk);
        rst = 1'b1;
        clear_all();
        @(negedge pclk);
        @(negedge pclk);
        rst = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while ((src0.size() > 0 || src1.size() > 0 || sb.size() > 0) && k < budget) begin
            step();
            k++;
        end
        check({name, "_sb_empty"}, 32'(sb.size()), 32'h0);
    endtask

    vec_t vt[8];

    initial begin
        int          got, a_base, p_base, base, l_base;
        logic [31:0] first;
        logic        cap, tog;
        int          exp_acc[12];

        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h11, 1'b1, 32'h22, 0, 32'h11};
        vt[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h11, 1'b1, 32'h22, 1, 32'h22};
        vt[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h33, 1, 32'h33};
        vt[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h44, 1'b1, 32'h45, 0, 32'h44};
        vt[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h54, 1'b1, 32'h55, 1, 32'h55};
        vt[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h000000FF, 1'b1, 32'h66, 0, 32'hFFFFFF00};
        vt[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h77, -1, 32'h0};
        vt[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h88, 1'b1, 32'hA5A5A5A5, 1, 32'h5A5A5A5A};
        exp_acc = '{-1, 0, 0, -1, 1, 1, -1, 0, 0, -1, 1, 1};

        do_reset();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_last", 32'(out_last), 32'h0);
        check("rst_grant_id", 32'(grant_id), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_trunc_err", 32'(trunc_err), 32'h0);
        check("rst_ch0_ready", 32'(ch0_ready), 32'h0);
        check("rst_ch1_ready", 32'(ch1_ready), 32'h0);

        for (int r = 0; r < 8; r++) begin
            arb_mode = vt[r].arb;
            channel_sel = vt[r].sel;
            data_inv = vt[r].inv;
            clear_all();
            if (vt[r].v0) src0.push_back('{vt[r].d0, 1'b1});
            if (vt[r].v1) src1.push_back('{vt[r].d1, 1'b1});
            drive();
            a_base = acc_cnt;
            p_base = pops;
            got = -1;
            for (int c = 0; c < 6; c++) begin
                step();
                if (acc_cnt != a_base && got < 0) begin
                    got = acc_ch;
                    src0.delete();
                    src1.delete();
                    drive();
                end
                if (pops != p_base) break;
            end
            check("tbl_grant", 32'(got), 32'(vt[r].exp_grant));
            check("tbl_pops", 32'(pops - p_base), (vt[r].exp_grant >= 0) ? 32'h1 : 32'h0);
            if (vt[r].exp_grant >= 0) check("tbl_data", last_out, vt[r].exp_data);
            clear_all();
            step();
            step();
        end

        // Reset in the middle of a ch0 packet; afterwards ch0 must win the first tie again.
        arb_mode = 1'b1;
        data_inv = 1'b0;
        for (int i = 0; i < 4; i++) src0.push_back('{32'h200 + 32'(i), (i == 3)});
        drive();
        base = n0_acc;
        for (int c = 0; c < 6 && (n0_acc - base) < 2; c++) step();
        check("rst_mid_accepts", 32'(n0_acc - base), 32'h2);
        rst = 1'b1;
        #1;
        check("rstmid_out_valid", 32'(out_valid), 32'h0);
        check("rstmid_out_data", out_data, 32'h0);
        check("rstmid_busy", 32'(busy), 32'h0);
        check("rstmid_ch0_ready", 32'(ch0_ready), 32'h0);
        clear_all();
        @(negedge pclk);
        rst = 1'b0;
        src0.push_back('{32'h2A0, 1'b1});
        src1.push_back('{32'h2A1, 1'b1});
        drive();
        got = -1;
        a_base = acc_cnt;
        for (int c = 0; c < 5 && got < 0; c++) begin
            step();
            if (acc_cnt != a_base) got = acc_ch;
        end
        check("rst_first_rr", 32'(got), 32'h0);
        drain("rst", 10);

        // Fixed mode on ch1 with both sources busy.
        do_reset();
        arb_mode = 1'b0;
        channel_sel = 1'b1;
        data_inv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            src0.push_back('{32'hC00000 + 32'(i), (i % 3 == 2)});
            src1.push_back('{32'hC10000 + 32'(i), (i % 3 == 2)});
        end
        drive();
        base = n0_acc;
        a_base = n1_acc;
        mon_no_ch0 = 1'b1;
        for (int c = 0; c < 14; c++) step();
        mon_no_ch0 = 1'b0;
        check("fix_ch1_beats", 32'(n1_acc - a_base), 32'h6);
        check("fix_ch0_beats", 32'(n0_acc - base), 32'h0);
        check("fix_sb_empty", 32'(sb.size()), 32'h0);
        clear_all();
        step();

        // Round robin, both always valid, 2-beat packets.
        do_reset();
        arb_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            src0.push_back('{32'hA000 + 32'(i), (i % 2 == 1)});
            src1.push_back('{32'hB000 + 32'(i), (i % 2 == 1)});
        end
        drive();
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("rr_seq%0d", i), 32'(cyc_acc), 32'(exp_acc[i]));
        end
        drain("rr", 6);

        // Inversion latched at grant; toggling mid-packet must not matter.
        arb_mode = 1'b0;
        channel_sel = 1'b0;
        data_inv = 1'b1;
        src0.push_back('{32'h000000FF, 1'b0});
        src0.push_back('{32'h00000F0F, 1'b0});
        src0.push_back('{32'h00001234, 1'b1});
        drive();
        p_base = pops;
        cap = 1'b0;
        tog = 1'b0;
        first = '0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (cyc_acc == 0 && !tog) begin
                data_inv = 1'b0;
                tog = 1'b1;
            end
            if (pops == p_base + 1 && !cap) begin
                first = last_out;
                cap = 1'b1;
            end
        end
        check("inv_first", first, 32'hFFFFFF00);
        check("inv_last", last_out, 32'hFFFFEDCB);
        check("inv_pops", 32'(pops - p_base), 32'h3);
        data_inv = 1'b0;
        clear_all();

        // 20 beats with last only on beat 20: forced end at beat 16.
        do_reset();
        #1;
        check("trunc_before", 32'(trunc_err), 32'h0);
        arb_mode = 1'b1;
        for (int i = 0; i < 20; i++) src0.push_back('{32'h600 + 32'(i), (i == 19)});
        drive();
        l_base = last_pops;
        p_base = pops;
        drain("trunc", 40);
        check("trunc_after", 32'(trunc_err), 32'h1);
        check("trunc_n_last", 32'(last_pops - l_base), 32'h2);
        check("trunc_pops", 32'(pops - p_base), 32'd20);

        // Downstream stall of 3 cycles mid-packet.
        for (int i = 0; i < 4; i++) src1.push_back('{32'h700 + 32'(i), (i == 3)});
        drive();
        p_base = pops;
        base = n1_acc;
        for (int c = 0; c < 6 && (n1_acc - base) < 2; c++) step();
        check("stall_pre_acc", 32'(n1_acc - base), 32'h2);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_ch1_ready", 32'(ch1_ready), 32'h0);
            check("stall_out_valid", 32'(out_valid), 32'h1);
            check("stall_out_data", out_data, 32'h701);
            step();
        end
        out_ready = 1'b1;
        drain("stall", 10);
        check("stall_pops", 32'(pops - p_base), 32'h4);
        check("stall_acc", 32'(n1_acc - base), 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
